// File: rtl/tcni_sched_pkg.sv
// Shared types for the TCNI injection scheduler: FSM states, slot payload, counter width.
package tcni_sched_pkg;

  localparam int unsigned SLOT_TIME_W = 32;
  localparam int unsigned MISS_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_SLOT,
    LAUNCH,
    BUSY,
    MISS,
    WAIT_EPOCH
  } tcni_sched_state;

  typedef struct packed {
    logic [SLOT_TIME_W-1:0] inj_time;
    logic [SLOT_TIME_W-3:0] loc;
  } tcni_slot_t;

endpackage

// File: rtl/tcni_injection_scheduler_if.sv
// Scheduler <-> sender handshake: launch pulse with slot payload, busy/done back.
interface tcni_injection_scheduler_if #(
  parameter int unsigned MBW = 32
);
  logic           sender_busy_in;
  logic           sender_done_in;
  logic           inj_start_out;
  logic [MBW-1:0] injection_time_out;
  logic [MBW-3:0] data_location_out;

  modport master (
    input  sender_busy_in, sender_done_in,
    output inj_start_out, injection_time_out, data_location_out
  );

  modport slave (
    output sender_busy_in, sender_done_in,
    input  inj_start_out, injection_time_out, data_location_out
  );
endinterface

// File: rtl/tcni_sched_table.sv
// Schedule slot register file: one synchronous write port, one registered read port.
module tcni_sched_table
  import tcni_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  tcni_slot_t       wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output tcni_slot_t       rd_data
);

  tcni_slot_t mem [DEPTH];

  // Table contents are intentionally not reset.
  always_ff @(posedge clock_in) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/tcni_injection_scheduler.sv
// Time-triggered injection scheduler: walks a slot table against a periodic time base,
// launching the sender at each slot time and counting slots that can no longer be met.
module tcni_injection_scheduler
  import tcni_sched_pkg::*;
#(
  parameter  int unsigned MEMORY_BUS_WIDTH = 32,
  parameter  int unsigned TABLE_DEPTH      = 8,
  localparam int unsigned IDX_W            = $clog2(TABLE_DEPTH)
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        enable_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] period_in,
  input  logic [IDX_W:0]              len_in,
  input  logic                        cfg_we_in,
  input  logic [IDX_W-1:0]            cfg_idx_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] cfg_time_in,
  input  logic [MEMORY_BUS_WIDTH-3:0] cfg_loc_in,
  input  logic                        miss_clr_in,
  tcni_injection_scheduler_if.master  snd,
  output logic [2:0]                  status_out,
  output logic [MISS_CNT_W-1:0]       miss_count_out,
  output logic [MEMORY_BUS_WIDTH-1:0] now_out
);

  localparam int unsigned MBW   = MEMORY_BUS_WIDTH;
  localparam int unsigned LEN_W = IDX_W + 1;

  tcni_sched_state       state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [MBW-1:0]        now_q, now_d;
  logic [MBW-1:0]        period_q, period_d;
  logic                  first_q;
  logic                  miss_sticky_q, miss_sticky_d;
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic                  inj_start_d;
  logic [MBW-1:0]        inj_time_d;
  logic [MBW-3:0]        inj_loc_d;
  logic [2:0]            status_d;
  logic                  rd_en_c;
  logic                  advance_c;
  logic                  miss_evt_c;
  logic [LEN_W-1:0]      eff_len_c;
  logic                  last_slot_c;
  tcni_slot_t            cfg_slot_c;
  tcni_slot_t            slot_q;

  assign cfg_slot_c = {cfg_time_in, cfg_loc_in};

  tcni_sched_table #(.DEPTH(TABLE_DEPTH)) u_table (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .we       (cfg_we_in),
    .wr_idx   (cfg_idx_in),
    .wr_data  (cfg_slot_c),
    .rd_en    (rd_en_c),
    .rd_idx   (ptr_q),
    .rd_data  (slot_q)
  );

  // Lengths beyond the table wrap at the table end; len 0 wraps immediately.
  assign eff_len_c   = (len_in > LEN_W'(TABLE_DEPTH)) ? LEN_W'(TABLE_DEPTH) : len_in;
  assign last_slot_c = (LEN_W'(ptr_q) + LEN_W'(1)) >= eff_len_c;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    period_d      = period_q;
    miss_sticky_d = miss_sticky_q;
    miss_cnt_d    = miss_cnt_q;
    rd_en_c       = 1'b0;
    advance_c     = 1'b0;
    miss_evt_c    = 1'b0;
    if (state_q == IDLE) begin
      now_d = '0;
    end else if (now_q == period_q - MBW'(1)) begin
      now_d = '0;
    end else begin
      now_d = now_q + MBW'(1);
    end

    case (state_q)
      IDLE: begin
        if (enable_in && !snd.sender_busy_in && (len_in != '0)) begin
          state_d  = FETCH;
          period_d = period_in;
        end
      end
      FETCH: begin
        rd_en_c = 1'b1;
        state_d = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        // Lateness is judged only on entry; afterwards now climbs toward the slot time.
        if (first_q && ((slot_q.inj_time < now_q) || (slot_q.inj_time >= period_q))) begin
          state_d = MISS;
        end else if (slot_q.inj_time == now_q) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH:     state_d = BUSY;
      BUSY:       advance_c = snd.sender_done_in;
      MISS: begin
        miss_evt_c = 1'b1;
        advance_c  = 1'b1;
      end
      WAIT_EPOCH: begin
        if (now_q == period_q - MBW'(1)) begin
          state_d = FETCH;
        end
      end
      default:    state_d = IDLE;
    endcase

    if (advance_c) begin
      if (last_slot_c) begin
        ptr_d   = '0;
        state_d = WAIT_EPOCH;
      end else begin
        ptr_d   = ptr_q + IDX_W'(1);
        state_d = FETCH;
      end
    end

    if (miss_evt_c) begin
      miss_sticky_d = 1'b1;
      if (miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
      end
    end
    if (miss_clr_in) begin
      miss_sticky_d = 1'b0;
      miss_cnt_d    = '0;
    end

    if (!enable_in) begin
      state_d = IDLE;
      ptr_d   = '0;
      now_d   = '0;
    end

    inj_start_d = (state_d == LAUNCH);
    inj_time_d  = inj_start_d ? slot_q.inj_time : '0;
    inj_loc_d   = inj_start_d ? slot_q.loc      : '0;
    status_d    = {miss_sticky_d, state_d == BUSY, state_d != IDLE};
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q                <= IDLE;
      ptr_q                  <= '0;
      now_q                  <= '0;
      period_q               <= '0;
      first_q                <= 1'b0;
      miss_sticky_q          <= 1'b0;
      miss_cnt_q             <= '0;
      status_out             <= '0;
      snd.inj_start_out      <= 1'b0;
      snd.injection_time_out <= '0;
      snd.data_location_out  <= '0;
    end else begin
      state_q                <= state_d;
      ptr_q                  <= ptr_d;
      now_q                  <= now_d;
      period_q               <= period_d;
      first_q                <= (state_q == FETCH);
      miss_sticky_q          <= miss_sticky_d;
      miss_cnt_q             <= miss_cnt_d;
      status_out             <= status_d;
      snd.inj_start_out      <= inj_start_d;
      snd.injection_time_out <= inj_time_d;
      snd.data_location_out  <= inj_loc_d;
    end
  end

  assign now_out        = now_q;
  assign miss_count_out = miss_cnt_q;

endmodule

// File: tb/tb_tcni_injection_scheduler.sv
// Self-checking bench for tcni_injection_scheduler: scoreboarded launches plus per-scenario checks.
module tb_tcni_injection_scheduler;
  import tcni_sched_pkg::*;

  typedef struct {
    logic [31:0] t;
    logic [29:0] loc;
    logic [31:0] now;
  } exp_t;

  logic        clock_in    = 1'b0;
  logic        reset_in    = 1'b0;
  logic        enable_in   = 1'b0;
  logic [31:0] period_in   = 32'd100;
  logic [3:0]  len_in      = 4'd0;
  logic        cfg_we_in   = 1'b0;
  logic [2:0]  cfg_idx_in  = 3'd0;
  logic [31:0] cfg_time_in = 32'd0;
  logic [29:0] cfg_loc_in  = 30'd0;
  logic        miss_clr_in = 1'b0;
  logic [2:0]  status_out;
  logic [7:0]  miss_count_out;
  logic [31:0] now_out;

  int   checks  = 0;
  int   errors  = 0;
  int   xfer_len = 5;
  exp_t exp_q[$];

  tcni_injection_scheduler_if #(.MBW(32)) snd_if ();

  tcni_injection_scheduler #(.MEMORY_BUS_WIDTH(32), .TABLE_DEPTH(8)) dut (
    .clock_in       (clock_in),
    .reset_in       (reset_in),
    .enable_in      (enable_in),
    .period_in      (period_in),
    .len_in         (len_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_idx_in     (cfg_idx_in),
    .cfg_time_in    (cfg_time_in),
    .cfg_loc_in     (cfg_loc_in),
    .miss_clr_in    (miss_clr_in),
    .snd            (snd_if.master),
    .status_out     (status_out),
    .miss_count_out (miss_count_out),
    .now_out        (now_out)
  );

  always #5 clock_in = ~clock_in;

  // Sender model: busy for xfer_len cycles after a launch, done pulse on the last one.
  initial begin
    snd_if.sender_busy_in = 1'b0;
    snd_if.sender_done_in = 1'b0;
    forever begin
      @(posedge clock_in); #1;
      if (snd_if.inj_start_out === 1'b1) begin
        snd_if.sender_busy_in = 1'b1;
        repeat (xfer_len - 1) begin @(posedge clock_in); #1; end
        snd_if.sender_done_in = 1'b1;
        @(posedge clock_in); #1;
        snd_if.sender_done_in = 1'b0;
        snd_if.sender_busy_in = 1'b0;
      end
    end
  end

  // Launch monitor: every start pulse must match the oldest expected launch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_in);
      if (snd_if.inj_start_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got time=%0d loc=%h now=%0d, required no start",
                   snd_if.injection_time_out, snd_if.data_location_out, now_out);
        end else begin
          e = exp_q.pop_front();
          if ({snd_if.injection_time_out, snd_if.data_location_out, now_out} !== {e.t, e.loc, e.now}) begin
            errors++;
            $display("FAIL launch: got time=%0d loc=%h now=%0d, required time=%0d loc=%h now=%0d",
                     snd_if.injection_time_out, snd_if.data_location_out, now_out, e.t, e.loc, e.now);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic write_slot(input int idx, input logic [31:0] t, input logic [29:0] loc);
    cfg_we_in = 1'b1; cfg_idx_in = 3'(idx); cfg_time_in = t; cfg_loc_in = loc;
    run(1);
    cfg_we_in = 1'b0;
  endtask

  task automatic clear_misses();
    miss_clr_in = 1'b1;
    run(1);
    miss_clr_in = 1'b0;
  endtask

  task automatic expect_launch(input logic [31:0] t, input logic [29:0] loc);
    exp_t e;
    e.t = t; e.loc = loc; e.now = t + 32'd1;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input logic [31:0] period, input logic [3:0] len);
    period_in = period; len_in = len; enable_in = 1'b1;
  endtask

  task automatic stop_run();
    enable_in = 1'b0;
    run(40);
  endtask

  task automatic test_reset();
    run(2);
    checks++;
    if ({snd_if.inj_start_out, snd_if.injection_time_out, snd_if.data_location_out,
         status_out, miss_count_out, now_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got status=%b count=%0d now=%0d start=%b, required all 0",
               status_out, miss_count_out, now_out, snd_if.inj_start_out);
    end
    reset_in = 1'b1;
    enable_in = 1'b1; len_in = 4'd0;
    run(5);
    checks++;
    if ({status_out, now_out} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL len_zero_idle: got status=%b now=%0d, required status=000 now=0", status_out, now_out);
    end
    enable_in = 1'b0;
    run(2);
  endtask

  task automatic test_nominal();
    write_slot(0, 32'd10, 30'h100);
    write_slot(1, 32'd50, 30'h200);
    clear_misses();
    xfer_len = 5;
    expect_launch(32'd10, 30'h100); expect_launch(32'd50, 30'h200);
    expect_launch(32'd10, 30'h100); expect_launch(32'd50, 30'h200);
    start_run(32'd100, 4'd2);
    run(30);
    checks++;
    if (now_out !== 32'd29) begin
      errors++; $display("FAIL nominal_now: got %0d, required 29", now_out);
    end
    run(71);
    checks++;
    if (now_out !== 32'd0) begin
      errors++; $display("FAIL nominal_wrap: got now=%0d, required 0", now_out);
    end
    run(59);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL nominal_drain: got %0d pending launches, required 0", exp_q.size());
    end
    checks++;
    if (miss_count_out !== 8'd0) begin
      errors++; $display("FAIL nominal_misses: got %0d, required 0", miss_count_out);
    end
    stop_run();
    exp_q.delete();
  endtask

  task automatic test_late_slot();
    write_slot(0, 32'd10, 30'hA0A);
    write_slot(1, 32'd12, 30'hB0B);
    clear_misses();
    xfer_len = 9;
    expect_launch(32'd10, 30'hA0A); expect_launch(32'd10, 30'hA0A);
    start_run(32'd100, 4'd2);
    run(51);
    checks++;
    if ({miss_count_out, status_out[2]} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL late_miss: got count=%0d sticky=%b, required count=1 sticky=1", miss_count_out, status_out[2]);
    end
    run(80);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL late_drain: got %0d pending launches, required 0", exp_q.size());
    end
    stop_run();
    exp_q.delete();
  endtask

  task automatic test_unreachable();
    write_slot(0, 32'd150, 30'h3FF);
    write_slot(1, 32'd20, 30'h300);
    clear_misses();
    xfer_len = 5;
    expect_launch(32'd20, 30'h300);
    start_run(32'd100, 4'd2);
    run(4);
    checks++;
    if ({miss_count_out, status_out[2]} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL unreach_miss: got count=%0d sticky=%b, required count=1 sticky=1", miss_count_out, status_out[2]);
    end
    run(30);
    checks++;
    if (exp_q.size() !== 0 || miss_count_out !== 8'd1) begin
      errors++;
      $display("FAIL unreach_advance: got pending=%0d count=%0d, required pending=0 count=1", exp_q.size(), miss_count_out);
    end
    stop_run();
    exp_q.delete();
  endtask

  task automatic test_stop_restart();
    int waited;
    write_slot(0, 32'd10, 30'h111);
    clear_misses();
    xfer_len = 30;
    expect_launch(32'd10, 30'h111);
    start_run(32'd100, 4'd1);
    run(15);
    checks++;
    if (status_out !== 3'b011) begin
      errors++; $display("FAIL stop_busy: got status=%b, required 011", status_out);
    end
    enable_in = 1'b0;
    run(1);
    checks++;
    if ({status_out, now_out} !== {3'b000, 32'd0}) begin
      errors++; $display("FAIL stop_idle: got status=%b now=%0d, required 000 now=0", status_out, now_out);
    end
    enable_in = 1'b1;
    run(3);
    checks++;
    if ({status_out, now_out, snd_if.sender_busy_in} !== {3'b000, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_hold: got status=%b now=%0d busy=%b, required 000 now=0 busy=1",
               status_out, now_out, snd_if.sender_busy_in);
    end
    waited = 0;
    while (snd_if.sender_busy_in === 1'b1 && waited < 100) begin
      run(1);
      waited++;
    end
    checks++;
    if (snd_if.sender_busy_in !== 1'b0 || status_out !== 3'b000) begin
      errors++;
      $display("FAIL restart_wait: got busy=%b status=%b, required busy=0 status=000", snd_if.sender_busy_in, status_out);
    end
    expect_launch(32'd10, 30'h111);
    run(1);
    checks++;
    if ({status_out, now_out} !== {3'b001, 32'd0}) begin
      errors++; $display("FAIL restart_fetch: got status=%b now=%0d, required 001 now=0", status_out, now_out);
    end
    run(15);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL restart_drain: got %0d pending launches, required 0", exp_q.size());
    end
    stop_run();
    exp_q.delete();
  endtask

  task automatic test_miss_saturate();
    for (int i = 0; i < 8; i++) write_slot(i, 32'd200, 30'(i));
    clear_misses();
    start_run(32'd4, 4'd8);
    run(1200);
    checks++;
    if ({miss_count_out, status_out[2]} !== {8'd255, 1'b1}) begin
      errors++;
      $display("FAIL miss_saturate: got count=%0d sticky=%b, required 255 sticky=1", miss_count_out, status_out[2]);
    end
  endtask

  task automatic test_async_reset();
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if ({snd_if.inj_start_out, snd_if.injection_time_out, snd_if.data_location_out,
         status_out, miss_count_out, now_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got status=%b count=%0d now=%0d start=%b, required all 0",
               status_out, miss_count_out, now_out, snd_if.inj_start_out);
    end
    enable_in = 1'b0;
    run(2);
    reset_in = 1'b1;
    run(3);
    checks++;
    if ({status_out, now_out} !== {3'b000, 32'd0}) begin
      errors++; $display("FAIL post_reset: got status=%b now=%0d, required 000 now=0", status_out, now_out);
    end
  endtask

  task automatic test_clr_coincident();
    for (int i = 0; i < 8; i++) write_slot(i, 32'd200, 30'(i));
    clear_misses();
    start_run(32'd4, 4'd8);
    run(15);
    checks++;
    if (miss_count_out !== 8'd4) begin
      errors++; $display("FAIL clr_before: got count=%0d, required 4", miss_count_out);
    end
    miss_clr_in = 1'b1;
    run(1);
    miss_clr_in = 1'b0;
    checks++;
    if ({miss_count_out, status_out[2]} !== {8'd0, 1'b0}) begin
      errors++;
      $display("FAIL clr_priority: got count=%0d sticky=%b, required 0 sticky=0", miss_count_out, status_out[2]);
    end
    run(3);
    checks++;
    if ({miss_count_out, status_out[2]} !== {8'd1, 1'b1}) begin
      errors++;
      $display("FAIL clr_resume: got count=%0d sticky=%b, required 1 sticky=1", miss_count_out, status_out[2]);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_late_slot();
    test_unreachable();
    test_stop_restart();
    test_miss_saturate();
    test_async_reset();
    test_clr_coincident();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
